// File: rtl/rx_fifo_sched.sv
// Rx FIFO write-through plus a two-consumer round-robin read scheduler.
// Optional saturating overrun counter: define RX_SCHED_OVR_CNT_EN to build it.
module rx_fifo_sched #(
  parameter int DBITS = 8
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             rx_done,
  input  logic [DBITS-1:0] rx_byte,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  input  logic [DBITS-1:0] fifo_rd_data,
  output logic             fifo_wr_en,
  output logic [DBITS-1:0] fifo_wr_data,
  output logic             fifo_rd_en,
  input  logic [1:0]       req,
  input  logic [1:0]       ack,
  output logic [1:0]       gnt,
  output logic [DBITS-1:0] data_out,
  output logic             data_valid,
  output logic             overrun,
  output logic [7:0]       overrun_cnt
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, DELIVER} state_t;

  state_t           state, state_nxt;
  logic             rd_en_nxt;
  logic [1:0]       gnt_nxt;
  logic             dv_nxt;
  logic [DBITS-1:0] data_nxt;
  logic             last, last_nxt;
  logic             winner;
  logic             overrun_evt;

  assign fifo_wr_en   = rx_done & ~fifo_full;
  assign fifo_wr_data = rx_byte;
  assign overrun_evt  = rx_done & fifo_full;

  // On a tie the consumer that did not win last time gets the byte.
  always_comb begin
    if (req == 2'b11) winner = ~last;
    else              winner = req[1];
  end

  always_comb begin
    state_nxt = state;
    rd_en_nxt = 1'b0;
    gnt_nxt   = gnt;
    dv_nxt    = data_valid;
    data_nxt  = data_out;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (req != 2'b00 && !fifo_empty) begin
          state_nxt = READ;
          rd_en_nxt = 1'b1;
          gnt_nxt   = winner ? 2'b10 : 2'b01;
          last_nxt  = winner;
        end
      end
      READ: state_nxt = WAIT;
      WAIT: begin
        state_nxt = DELIVER;
        data_nxt  = fifo_rd_data;
        dv_nxt    = 1'b1;
      end
      DELIVER: begin
        // A consumer withdrawing its request forfeits the byte.
        if ((ack & gnt) != 2'b00 || (req & gnt) == 2'b00) begin
          state_nxt = IDLE;
          dv_nxt    = 1'b0;
          gnt_nxt   = 2'b00;
        end
      end
      default: begin
        state_nxt = IDLE;
        dv_nxt    = 1'b0;
        gnt_nxt   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state      <= IDLE;
      fifo_rd_en <= 1'b0;
      gnt        <= 2'b00;
      data_valid <= 1'b0;
      data_out   <= '0;
      last       <= 1'b1;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      fifo_rd_en <= rd_en_nxt;
      gnt        <= gnt_nxt;
      data_valid <= dv_nxt;
      data_out   <= data_nxt;
      last       <= last_nxt;
      if (overrun_evt) overrun <= 1'b1;
    end
  end

`ifdef RX_SCHED_OVR_CNT_EN
  logic [7:0] ovr_cnt;

  always_ff @(posedge clk or negedge areset) begin
    if (!areset)                              ovr_cnt <= 8'd0;
    else if (overrun_evt && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
  end

  assign overrun_cnt = ovr_cnt;
`else
  assign overrun_cnt = 8'd0;
`endif

endmodule
